// File: rtl/bin_to_7seg_mux.sv
// Time-multiplexed N-digit hex 7-segment driver (common anode, active-low) with frame-coherent shadow.
// Optional build macro LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 always shown).
module bin_to_7seg_mux #(
   parameter int unsigned N_DIGITS    = 4,
   parameter int unsigned REFRESH_DIV = 100000
) (
   input  logic                    reloj,
   input  logic                    reset,
   input  logic                    en,
   input  logic [4*N_DIGITS-1:0]   in,
   output logic [6:0]              seg_out,
   output logic [N_DIGITS-1:0]     an_out,
   output logic                    frame_done
);

   localparam int unsigned IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
   localparam int unsigned PRESC_W = $clog2(REFRESH_DIV);
   localparam int unsigned SHD_W   = 4 * N_DIGITS;

   logic [PRESC_W-1:0] presc, presc_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [SHD_W-1:0]   shadow, shadow_nxt;
   logic               primed, primed_nxt;
   logic               tick, wrap;
   logic [3:0]         digit;
   logic [6:0]         seg_nxt;
   logic [N_DIGITS-1:0] an_nxt;
   logic               blank_sel;
`ifdef LEADING_ZERO_BLANK_EN
   logic               upper_zero;
`endif

   function automatic logic [6:0] decode(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   // Scan state: the priming cycle captures `in` but leaves presc untouched so every dwell is full length
   always_comb begin
      presc_nxt  = presc;
      idx_nxt    = idx;
      shadow_nxt = shadow;
      primed_nxt = primed;
      tick = en && primed && (presc == PRESC_W'(REFRESH_DIV - 1));
      wrap = tick && (idx == IDX_W'(N_DIGITS - 1));
      if (en) begin
         if (!primed) begin
            shadow_nxt = in;
            primed_nxt = 1'b1;
         end else if (tick) begin
            presc_nxt = '0;
            if (wrap) begin
               idx_nxt    = '0;
               shadow_nxt = in;
            end else begin
               idx_nxt = idx + IDX_W'(1);
            end
         end else begin
            presc_nxt = presc + PRESC_W'(1);
         end
      end
   end

   // Output drive computed from the post-update index and shadow
   always_comb begin
      digit     = 4'h0;
      an_nxt    = '1;
      blank_sel = 1'b0;
      for (int i = 0; i < int'(N_DIGITS); i++) begin
         if (idx_nxt == IDX_W'(i)) begin
            digit = shadow_nxt[4*i +: 4];
            if (en) an_nxt[i] = 1'b0;
         end
      end
`ifdef LEADING_ZERO_BLANK_EN
      upper_zero = 1'b1;
      for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
         upper_zero = upper_zero && (shadow_nxt[4*i +: 4] == 4'h0);
         if ((idx_nxt == IDX_W'(i)) && upper_zero) blank_sel = 1'b1;
      end
`endif
      if (en && !blank_sel) seg_nxt = decode(digit);
      else                  seg_nxt = 7'h7F;
   end

   always_ff @(posedge reloj or posedge reset) begin
      if (reset) begin
         presc      <= '0;
         idx        <= '0;
         shadow     <= '0;
         primed     <= 1'b0;
         an_out     <= '1;
         seg_out    <= 7'h7F;
         frame_done <= 1'b0;
      end else begin
         presc      <= presc_nxt;
         idx        <= idx_nxt;
         shadow     <= shadow_nxt;
         primed     <= primed_nxt;
         an_out     <= an_nxt;
         seg_out    <= seg_nxt;
         frame_done <= wrap;
      end
   end

endmodule
